// File: rtl/scale_step_ctrl_pkg.sv
// Shared definitions for the Scale step controller: default widths, FSM
// state codes and the step-direction type used between FSM and Scale logic.
package scale_step_ctrl_pkg;

  // Default Scale width; the Divider reads the same value.
  localparam int SCALE_W_DEF = 6;

  // FSM state codes (3-bit, shared encoding).
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD_UP = 3'd1;
  localparam logic [2:0] ST_HOLD_DN = 3'd2;
  localparam logic [2:0] ST_RPT_UP  = 3'd3;
  localparam logic [2:0] ST_RPT_DN  = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  // Step request from the FSM to the Scale register.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } step_e;

  // True for the states that belong to a held Plus button.
  function automatic logic is_up_state(input logic [2:0] st);
    return (st == ST_HOLD_UP) || (st == ST_RPT_UP);
  endfunction

  // True for the auto-repeat states (as opposed to the initial hold wait).
  function automatic logic is_rpt_state(input logic [2:0] st);
    return (st == ST_RPT_UP) || (st == ST_RPT_DN);
  endfunction

endpackage

// File: rtl/scale_step_ctrl_btn_edge_detect.sv
// Rising-edge detector for one debounced button level. The previous-level
// register resets to 1 so a button held through reset never counts as a press.
module btn_edge_detect (
  input  logic sysclk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_q;

  // Remember the level sampled at the previous edge.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/scale_step_ctrl.sv
// Scale step controller: converts debounced Plus/Minus levels into the
// saturating Scale word for the frequency Divider, with press-to-step,
// hold-then-auto-repeat, both-buttons lockout, limit flags and a step strobe.
module scale_step_ctrl
  import scale_step_ctrl_pkg::*;
#(
  parameter int SCALE_W       = SCALE_W_DEF,
  parameter int SCALE_MIN     = 0,
  parameter int SCALE_MAX     = 63,
  parameter int SCALE_RST     = 8,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int TIMER_W       = 26
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               Plus,
  input  logic               Minus,
  output logic [SCALE_W-1:0] Scale,
  output logic               At_Max,
  output logic               At_Min,
  output logic               Step_Pulse
);

  localparam logic [SCALE_W-1:0] MIN_V      = SCALE_W'(SCALE_MIN);
  localparam logic [SCALE_W-1:0] MAX_V      = SCALE_W'(SCALE_MAX);
  localparam logic [SCALE_W-1:0] RST_V      = SCALE_W'(SCALE_RST);
  localparam logic [SCALE_W-1:0] ONE_V      = SCALE_W'(1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RPT_LAST   = TIMER_W'(REPEAT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic               RST_AT_MAX = (RST_V == MAX_V);
  localparam logic               RST_AT_MIN = (RST_V == MIN_V);

  logic [2:0]         state_q;
  logic [2:0]         state_nxt;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_nxt;
  logic [SCALE_W-1:0] scale_q;
  logic [SCALE_W-1:0] scale_nxt;
  logic               at_max_q;
  logic               at_min_q;
  logic               step_pulse_q;
  logic               changed;
  step_e              step_req;

  logic plus_rise;
  logic minus_rise;
  logic dir_up;
  logic own_level;
  logic other_level;
  logic [TIMER_W-1:0] last_tick;

  btn_edge_detect u_plus_edge (
    .sysclk (sysclk),
    .reset  (reset),
    .level  (Plus),
    .rise   (plus_rise)
  );

  btn_edge_detect u_minus_edge (
    .sysclk (sysclk),
    .reset  (reset),
    .level  (Minus),
    .rise   (minus_rise)
  );

  // In the hold/repeat states, "own" is the button that started the hold.
  assign dir_up      = is_up_state(state_q);
  assign own_level   = dir_up ? Plus  : Minus;
  assign other_level = dir_up ? Minus : Plus;
  assign last_tick   = is_rpt_state(state_q) ? RPT_LAST : HOLD_LAST;

  // Next-state, timer and step-request decode.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    step_req  = STEP_NONE;
    case (state_q)
      ST_IDLE: begin
        timer_nxt = '0;
        if (Plus && Minus) begin
          state_nxt = ST_LOCKOUT;
        end else if (plus_rise) begin
          step_req  = STEP_UP;
          state_nxt = ST_HOLD_UP;
        end else if (minus_rise) begin
          step_req  = STEP_DN;
          state_nxt = ST_HOLD_DN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD_UP, ST_HOLD_DN, ST_RPT_UP, ST_RPT_DN: begin
        if (!own_level) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (other_level) begin
          state_nxt = ST_LOCKOUT;
          timer_nxt = '0;
        end else if (timer_q == last_tick) begin
          timer_nxt = '0;
          step_req  = dir_up ? STEP_UP : STEP_DN;
          state_nxt = dir_up ? ST_RPT_UP : ST_RPT_DN;
        end else begin
          timer_nxt = timer_q + TIMER_ONE;
        end
      end
      ST_LOCKOUT: begin
        timer_nxt = '0;
        if (!Plus && !Minus) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_LOCKOUT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Saturating +/-1: limits are checked before the add so Scale never wraps.
  always_comb begin
    scale_nxt = scale_q;
    changed   = 1'b0;
    case (step_req)
      STEP_UP: begin
        if (scale_q < MAX_V) begin
          scale_nxt = scale_q + ONE_V;
          changed   = 1'b1;
        end else begin
          scale_nxt = scale_q;
          changed   = 1'b0;
        end
      end
      STEP_DN: begin
        if (scale_q > MIN_V) begin
          scale_nxt = scale_q - ONE_V;
          changed   = 1'b1;
        end else begin
          scale_nxt = scale_q;
          changed   = 1'b0;
        end
      end
      default: begin
        scale_nxt = scale_q;
        changed   = 1'b0;
      end
    endcase
  end

  // FSM state and hold/repeat timer.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
    end
  end

  // Scale register plus flags derived from next-Scale so they move together.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      scale_q      <= RST_V;
      at_max_q     <= RST_AT_MAX;
      at_min_q     <= RST_AT_MIN;
      step_pulse_q <= 1'b0;
    end else begin
      scale_q      <= scale_nxt;
      at_max_q     <= (scale_nxt == MAX_V);
      at_min_q     <= (scale_nxt == MIN_V);
      step_pulse_q <= changed;
    end
  end

  assign Scale      = scale_q;
  assign At_Max     = at_max_q;
  assign At_Min     = at_min_q;
  assign Step_Pulse = step_pulse_q;

endmodule
